// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns PC and IR, fetches instructions over a req/ack
// memory handshake and applies the controller's PC/IR commands.
module fetch_unit #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              LoadIR,
   input  logic              IncPC,
   input  logic              SelPC,
   input  logic              LoadPC,
   input  logic [DATA_W-1:0] RegData,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [7:0]        mem_rdata,
   output logic [7:0]        Opcode,
   output logic [DATA_W-1:0] Immediate,
   output logic [ADDR_W-1:0] PC,
   output logic              ir_valid,
   output logic              stall,
   output logic              halted
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HALT  = 2'd2
   } state_t;

   state_t state_q;
   state_t state_d;

   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [7:0]        ir_q, ir_d;
   logic              ir_valid_q, ir_valid_d;
   logic              halted_q, halted_d;
   logic              req_q, req_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              stall_q, stall_d;

   logic [DATA_W-1:0] jump_target;
   logic [ADDR_W-1:0] jump_addr;
   logic              halt_opcode;
   logic              start_fetch;

   assign Immediate   = DATA_W'(ir_q[3:0]);
   assign jump_target = SelPC ? Immediate : RegData;
   assign jump_addr   = ADDR_W'(jump_target);
   assign halt_opcode = (mem_rdata[7:4] == 4'hF);
   assign start_fetch = LoadIR && !halted_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start_fetch) begin
               state_d = FETCH;
            end
         end
         FETCH: begin
            if (mem_ack) begin
               state_d = halt_opcode ? HALT : IDLE;
            end
         end
         HALT: begin
            state_d = HALT;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // LoadIR outranks LoadPC, which outranks IncPC; only IDLE accepts commands.
   always_comb begin
      pc_d       = pc_q;
      ir_d       = ir_q;
      ir_valid_d = ir_valid_q;
      halted_d   = halted_q;
      req_d      = req_q;
      addr_d     = addr_q;
      stall_d    = stall_q;
      case (state_q)
         IDLE: begin
            if (start_fetch) begin
               req_d   = 1'b1;
               addr_d  = pc_q;
               stall_d = 1'b1;
            end else if (LoadPC) begin
               pc_d = jump_addr;
            end else if (IncPC) begin
               pc_d = pc_q + ADDR_W'(1);
            end
         end
         FETCH: begin
            if (mem_ack) begin
               ir_d       = mem_rdata;
               ir_valid_d = 1'b1;
               req_d      = 1'b0;
               stall_d    = 1'b0;
               if (halt_opcode) begin
                  halted_d = 1'b1;
               end
            end
         end
         HALT: begin
            req_d   = 1'b0;
            stall_d = 1'b0;
         end
         default: begin
            req_d   = 1'b0;
            stall_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q       <= RESET_PC;
         ir_q       <= 8'h00;
         ir_valid_q <= 1'b0;
         halted_q   <= 1'b0;
         req_q      <= 1'b0;
         addr_q     <= '0;
         stall_q    <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         ir_q       <= ir_d;
         ir_valid_q <= ir_valid_d;
         halted_q   <= halted_d;
         req_q      <= req_d;
         addr_q     <= addr_d;
         stall_q    <= stall_d;
      end
   end

   assign PC       = pc_q;
   assign Opcode   = ir_q;
   assign ir_valid = ir_valid_q;
   assign halted   = halted_q;
   assign mem_req  = req_q;
   assign mem_addr = addr_q;
   assign stall    = stall_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios followed by random
// stimulus, all compared each cycle against a transaction-level model.
module tb_fetch_unit;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned DATA_W = 8;
   localparam logic [7:0] RESET_PC = 8'h00;

   logic              clk = 1'b0;
   logic              reset;
   logic              LoadIR, IncPC, SelPC, LoadPC;
   logic [DATA_W-1:0] RegData;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [7:0]        mem_rdata;
   logic [7:0]        Opcode;
   logic [DATA_W-1:0] Immediate;
   logic [ADDR_W-1:0] PC;
   logic              ir_valid, stall, halted;

   int total = 0;
   int bad   = 0;

   // Model: a fetch is either pending (address captured) or not; halted blocks all.
   int  mPc, mOp, mAddr;
   bit  mValid, mHalted, mPending;

   fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .reset(reset), .LoadIR(LoadIR), .IncPC(IncPC), .SelPC(SelPC),
      .LoadPC(LoadPC), .RegData(RegData), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .Opcode(Opcode), .Immediate(Immediate),
      .PC(PC), .ir_valid(ir_valid), .stall(stall), .halted(halted)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic modelStep(input bit rst, input bit ldir, input bit inc, input bit sel,
                            input bit ldpc, input int rd, input bit ack, input int rdata);
      if (rst) begin
         mPc = RESET_PC; mOp = 0; mValid = 0; mHalted = 0; mPending = 0; mAddr = 0;
      end else if (mHalted) begin
         // frozen until reset
      end else if (mPending) begin
         if (ack) begin
            mOp = rdata; mValid = 1; mPending = 0;
            if ((rdata / 16) == 15) mHalted = 1;
         end
      end else if (ldir) begin
         mPending = 1; mAddr = mPc;
      end else if (ldpc) begin
         mPc = sel ? (mOp % 16) : (rd % 256);
      end else if (inc) begin
         mPc = (mPc + 1) % 256;
      end
   endtask

   task automatic applyStimulus(input bit rst, input bit ldir, input bit inc, input bit sel,
                                input bit ldpc, input logic [7:0] rd, input bit ack,
                                input logic [7:0] rdata);
      reset = rst; LoadIR = ldir; IncPC = inc; SelPC = sel; LoadPC = ldpc;
      RegData = rd; mem_ack = ack; mem_rdata = rdata;
      @(posedge clk);
      modelStep(rst, ldir, inc, sel, ldpc, int'(rd), ack, int'(rdata));
      #1;
      checkOutput("pc",       32'(PC),        32'(mPc));
      checkOutput("opcode",   32'(Opcode),    32'(mOp));
      checkOutput("imm",      32'(Immediate), 32'(mOp % 16));
      checkOutput("ir_valid", 32'(ir_valid),  32'(mValid));
      checkOutput("halted",   32'(halted),    32'(mHalted));
      checkOutput("mem_req",  32'(mem_req),   32'(mPending));
      checkOutput("stall",    32'(stall),     32'(mPending));
      if (mPending || rst) checkOutput("mem_addr", 32'(mem_addr), 32'(mAddr));
   endtask

   initial begin
      mPc = 0; mOp = 0; mAddr = 0; mValid = 0; mHalted = 0; mPending = 0;
      applyStimulus(1, 0, 0, 0, 0, 8'h00, 0, 8'h00);
      applyStimulus(1, 0, 0, 0, 0, 8'h00, 0, 8'h00);

      // basic fetch, ack one cycle after the request
      applyStimulus(0, 1, 0, 0, 0, 8'h00, 0, 8'h00);
      checkOutput("t1_req", 32'(mem_req), 32'd1);
      applyStimulus(0, 0, 0, 0, 0, 8'h00, 1, 8'h1A);
      checkOutput("t1_op",    32'(Opcode),    32'h1A);
      checkOutput("t1_imm",   32'(Immediate), 32'h0A);
      checkOutput("t1_valid", 32'(ir_valid),  32'd1);
      checkOutput("t1_pc",    32'(PC),        32'h00);
      checkOutput("t1_stall", 32'(stall),     32'd0);

      // PC wrap
      applyStimulus(0, 0, 0, 0, 1, 8'hFE, 0, 8'h00);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 0, 8'h00, 0, 8'h00);
      checkOutput("t2_pc", 32'(PC), 32'h01);

      // jump target selection and priority over IncPC
      applyStimulus(0, 1, 0, 0, 0, 8'h00, 0, 8'h00);
      applyStimulus(0, 0, 0, 0, 0, 8'h00, 1, 8'h73);
      applyStimulus(0, 0, 0, 1, 1, 8'h40, 0, 8'h00);
      checkOutput("t3_imm_jump", 32'(PC), 32'h03);
      applyStimulus(0, 0, 0, 0, 1, 8'h40, 0, 8'h00);
      checkOutput("t3_reg_jump", 32'(PC), 32'h40);
      applyStimulus(0, 0, 1, 1, 1, 8'h40, 0, 8'h00);
      checkOutput("t3_jump_vs_inc", 32'(PC), 32'h03);

      // delayed ack with commands during the wait, then a stray ack in IDLE
      applyStimulus(0, 1, 0, 0, 0, 8'h00, 0, 8'h00);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(0, 1, 1, i[0], 1, 8'hA5, 0, 8'h00);
         checkOutput("t4_req_hold",  32'(mem_req),  32'd1);
         checkOutput("t4_addr_hold", 32'(mem_addr), 32'h03);
      end
      applyStimulus(0, 0, 0, 0, 0, 8'h00, 1, 8'h22);
      checkOutput("t4_pc", 32'(PC), 32'h03);
      applyStimulus(0, 0, 0, 0, 0, 8'h00, 1, 8'h99);
      checkOutput("t4_stray_ack", 32'(Opcode), 32'h22);

      // HALT opcode freezes everything until reset
      applyStimulus(0, 1, 0, 0, 0, 8'h00, 0, 8'h00);
      applyStimulus(0, 0, 0, 0, 0, 8'h00, 1, 8'hF0);
      checkOutput("t5_halted", 32'(halted), 32'd1);
      for (int i = 0; i < 4; i++) applyStimulus(0, 1, 1, i[0], 1, 8'h11, 1, 8'h11);
      checkOutput("t5_req", 32'(mem_req), 32'd0);
      checkOutput("t5_pc",  32'(PC),      32'h03);
      checkOutput("t5_op",  32'(Opcode),  32'hF0);
      applyStimulus(1, 0, 0, 0, 0, 8'h00, 0, 8'h00);
      checkOutput("t5_rst_pc",     32'(PC),     32'(RESET_PC));
      checkOutput("t5_rst_halted", 32'(halted), 32'd0);

      // reset in the middle of a fetch; the late ack must be ignored
      applyStimulus(0, 1, 0, 0, 0, 8'h00, 0, 8'h00);
      applyStimulus(1, 0, 0, 0, 0, 8'h00, 0, 8'h00);
      applyStimulus(0, 0, 0, 0, 0, 8'h00, 1, 8'h55);
      checkOutput("t6_req",   32'(mem_req),  32'd0);
      checkOutput("t6_op",    32'(Opcode),   32'h00);
      checkOutput("t6_valid", 32'(ir_valid), 32'd0);

      for (int i = 0; i < 3000; i++) begin
         logic [7:0] rdv;
         rdv = 8'($urandom);
         if ($urandom_range(0, 5) != 0 && rdv[7:4] == 4'hF) rdv[7] = 1'b0;
         applyStimulus($urandom_range(0, 63) == 0, $urandom_range(0, 2) == 0,
                       1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0,
                       8'($urandom), $urandom_range(0, 2) == 0, rdv);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Upstream neighbour of the instruction-sequencing controller. Owns the program counter (PC) and the instruction register (IR).
- Fetches 8-bit instructions from instruction memory over a req/ack handshake and presents Opcode/Immediate to the controller.
- Applies the controller's LoadIR/IncPC/SelPC/LoadPC commands.
- Raises stall while a fetch is outstanding and latches halted on a HALT opcode.

Parameters:
ADDR_W, 8, PC and memory address width
DATA_W, 8, width of Immediate and RegData
RESET_PC, 0, PC value after reset

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
LoadIR  input  1  controller request: fetch instruction at PC into IR
IncPC  input  1  controller request: PC <= PC+1
SelPC  input  1  jump target select: 0 = RegData, 1 = Immediate
LoadPC  input  1  controller request: PC <= selected jump target
RegData  input  DATA_W  register-file value used as jump target
mem_req  output  1  instruction memory read request
mem_addr  output  ADDR_W  read address, equals PC captured at request
mem_ack  input  1  memory response valid; mem_rdata valid in same cycle
mem_rdata  input  8  instruction word
Opcode  output  8  current IR contents
Immediate  output  DATA_W  IR[3:0] zero-extended
PC  output  ADDR_W  current program counter
ir_valid  output  1  IR holds a fetched instruction
stall  output  1  fetch outstanding; controller must hold its stage
halted  output  1  HALT (IR[7:4]=4'b1111) captured

Behaviour:
- Reset is synchronous and active-high. When reset is high at a clock edge, the following values apply:
  - PC=RESET_PC, Opcode=8'h00, ir_valid=0, halted=0
  - mem_req=0, mem_addr=0, stall=0
  - state=IDLE
  - Reset overrides every other input, including mid-fetch. A mem_ack arriving after reset is ignored.
- FSM has three states: IDLE, FETCH, HALT.
  - IDLE with LoadIR=1 and halted=0: next cycle mem_req=1, mem_addr=PC, stall=1, state=FETCH. IncPC/LoadPC sampled in the same cycle are dropped, because LoadIR has priority.
  - IDLE with LoadIR=0: LoadPC=1 loads PC with the target. The target is SelPC ? Immediate : RegData, truncated or zero-extended to ADDR_W. If LoadPC=0 and IncPC=1, PC <= PC+1 mod 2^ADDR_W, so 2^ADDR_W-1 wraps to 0. LoadPC has priority over IncPC.
  - FETCH: mem_req and mem_addr are held stable until mem_ack. LoadIR/IncPC/LoadPC are ignored.
  - FETCH on mem_ack: Opcode <= mem_rdata, ir_valid <= 1. mem_req, stall and IR update all take effect at the same edge: next cycle mem_req=0, stall=0.
    - If mem_rdata[7:4]==4'b1111, halted <= 1 and state=HALT.
    - Otherwise state=IDLE.
  - HALT: all controller commands are ignored. PC and IR are frozen, mem_req=0. Only reset leaves HALT.
- Fetch latency: request issued 1 cycle after LoadIR. IR updated at the edge of the mem_ack cycle. Minimum LoadIR-to-Opcode latency is 2 cycles.
- mem_ack while not in FETCH is ignored, with no state change.
- ir_valid remains 1 once set, until reset.
- Immediate is combinational from IR[3:0]. PC, Opcode, mem_addr and stall are registered outputs.

Test Plan:
1. Reset then LoadIR pulse, memory acks 1 cycle after req with 8'h1A. Required response: mem_addr=0, stall high exactly during FETCH, Opcode=8'h1A, Immediate=8'h0A, ir_valid=1, PC unchanged (0).
2. IDLE, IncPC pulsed 3 times from PC=8'hFE. Required response: PC goes FE, FF, 00, 01, and no mem_req is issued.
3. IR=8'h73, RegData=8'h40. LoadPC+SelPC=1 gives PC=8'h03. LoadPC+SelPC=0 gives PC=8'h40. LoadPC+IncPC together gives the jump target, not the increment.
4. LoadIR with mem_ack delayed 5 cycles. Required response: mem_req/mem_addr stable for all 5 cycles. IncPC/LoadPC pulsed during the wait leave PC unchanged. A stray mem_ack in IDLE leaves Opcode unchanged.
5. Fetch returns 8'hF0. Required response: halted=1. Subsequent LoadIR/IncPC/LoadPC produce no mem_req and no PC/IR change. Reset then returns PC=RESET_PC, halted=0.
6. Reset asserted in a FETCH cycle before ack, then ack the next cycle with 8'h55. Required response: mem_req=0 after reset, Opcode=8'h00, ir_valid=0, state IDLE.
